// File: rtl/alu_arbiter_if.sv
// Requester, ALU-side and response signals shared between alu_arbiter and its environment.
interface alu_arbiter_if;
  localparam int unsigned INSTR_W = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FLAGS_W = 5;

  logic               r0_valid;
  logic               r0_ready;
  logic [INSTR_W-1:0] r0_instr;
  logic [DATA_W-1:0]  r0_dat1;
  logic [DATA_W-1:0]  r0_dat2;
  logic               r1_valid;
  logic               r1_ready;
  logic [INSTR_W-1:0] r1_instr;
  logic [DATA_W-1:0]  r1_dat1;
  logic [DATA_W-1:0]  r1_dat2;

  logic               alu_dat_ready;
  logic [INSTR_W-1:0] alu_instr;
  logic [DATA_W-1:0]  alu_dat1;
  logic [DATA_W-1:0]  alu_dat2;
  logic               alu_ready;
  logic [DATA_W-1:0]  alu_out;
  logic               alu_overflow;
  logic               alu_con_met;
  logic               alu_zero;
  logic               alu_err;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [DATA_W-1:0]  rsp_out;
  logic [FLAGS_W-1:0] rsp_flags;
  logic               busy;

  modport slave (
    input  r0_valid, r0_instr, r0_dat1, r0_dat2,
           r1_valid, r1_instr, r1_dat1, r1_dat2,
           alu_ready, alu_out, alu_overflow, alu_con_met, alu_zero, alu_err,
           rsp_ready,
    output r0_ready, r1_ready,
           alu_dat_ready, alu_instr, alu_dat1, alu_dat2,
           rsp_valid, rsp_id, rsp_out, rsp_flags, busy
  );

  modport master (
    output r0_valid, r0_instr, r0_dat1, r0_dat2,
           r1_valid, r1_instr, r1_dat1, r1_dat2,
           alu_ready, alu_out, alu_overflow, alu_con_met, alu_zero, alu_err,
           rsp_ready,
    input  r0_ready, r1_ready,
           alu_dat_ready, alu_instr, alu_dat1, alu_dat2,
           rsp_valid, rsp_id, rsp_out, rsp_flags, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with timeout and a
// single tagged valid/ready response channel.
module alu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic          soc_clk,
  input  logic          reset,
  alu_arbiter_if.slave  io_bus
);
  localparam int unsigned INSTR_W = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FLAGS_W = 5;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_W1  = CNT_W + 1;
  localparam logic [FLAGS_W-1:0] FLAGS_ERR = 5'b01000;
  localparam logic [FLAGS_W-1:0] FLAGS_TMO = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  state_e             r_state;
  state_e             w_state_n;
  logic               r_last;
  logic               r_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [INSTR_W-1:0] r_instr;
  logic [DATA_W-1:0]  r_dat1;
  logic [DATA_W-1:0]  r_dat2;
  logic [DATA_W-1:0]  r_rsp_out;
  logic [FLAGS_W-1:0] r_rsp_flags;
  logic               r_dat_ready;
  logic               r_rsp_valid;
  logic               r_busy;

  logic               w_grant_vld;
  logic               w_grant_id;
  logic [INSTR_W-1:0] w_req_instr;
  logic [DATA_W-1:0]  w_req_dat1;
  logic [DATA_W-1:0]  w_req_dat2;
  logic               w_alu_done;
  logic               w_timeout;
  logic               w_cnt_hit;

  assign w_cnt_hit = ({1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1}) == CNT_W1'(TIMEOUT_CYCLES);

  // Grant selection and next-state; a tie goes to the requester not granted last
  always_comb begin
    w_state_n   = r_state;
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    w_alu_done  = 1'b0;
    w_timeout   = 1'b0;
    w_req_instr = io_bus.r0_instr;
    w_req_dat1  = io_bus.r0_dat1;
    w_req_dat2  = io_bus.r0_dat2;

    case (r_state)
      ST_IDLE: begin
        if (io_bus.r0_valid && io_bus.r1_valid) begin
          w_grant_vld = 1'b1;
          w_grant_id  = ~r_last;
        end else if (io_bus.r0_valid) begin
          w_grant_vld = 1'b1;
        end else if (io_bus.r1_valid) begin
          w_grant_vld = 1'b1;
          w_grant_id  = 1'b1;
        end
        if (w_grant_id) begin
          w_req_instr = io_bus.r1_instr;
          w_req_dat1  = io_bus.r1_dat1;
          w_req_dat2  = io_bus.r1_dat2;
        end
        if (w_grant_vld) begin
          w_state_n = w_req_instr[INSTR_W-1] ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (io_bus.alu_ready) begin
          w_alu_done = 1'b1;
          w_state_n  = ST_RESP;
        end else if (w_cnt_hit) begin
          w_timeout = 1'b1;
          w_state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        if (io_bus.rsp_ready) w_state_n = ST_GAP;
      end
      ST_GAP:  w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  // Operand latch, timeout counter and response capture
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_cnt       <= '0;
      r_instr     <= '0;
      r_dat1      <= '0;
      r_dat2      <= '0;
      r_rsp_out   <= '0;
      r_rsp_flags <= '0;
      r_dat_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_dat_ready <= (w_state_n == ST_BUSY);
      r_rsp_valid <= (w_state_n == ST_RESP);
      r_busy      <= (w_state_n != ST_IDLE);

      if (w_grant_vld) begin
        r_instr <= w_req_instr;
        r_dat1  <= w_req_dat1;
        r_dat2  <= w_req_dat2;
        r_id    <= w_grant_id;
        r_last  <= w_grant_id;
        r_cnt   <= '0;
        if (w_req_instr[INSTR_W-1]) begin
          r_rsp_out   <= '0;
          r_rsp_flags <= FLAGS_ERR;
        end
      end

      if (r_state == ST_BUSY && !w_alu_done && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_alu_done) begin
        r_rsp_out   <= io_bus.alu_out;
        r_rsp_flags <= {1'b0, io_bus.alu_err, io_bus.alu_zero,
                        io_bus.alu_con_met, io_bus.alu_overflow};
      end else if (w_timeout) begin
        r_rsp_out   <= '0;
        r_rsp_flags <= FLAGS_TMO;
      end
    end
  end

  assign io_bus.r0_ready      = w_grant_vld & ~w_grant_id;
  assign io_bus.r1_ready      = w_grant_vld &  w_grant_id;
  assign io_bus.alu_dat_ready = r_dat_ready;
  assign io_bus.alu_instr     = r_instr;
  assign io_bus.alu_dat1      = r_dat1;
  assign io_bus.alu_dat2      = r_dat2;
  assign io_bus.rsp_valid     = r_rsp_valid;
  assign io_bus.rsp_id        = r_id;
  assign io_bus.rsp_out       = r_rsp_out;
  assign io_bus.rsp_flags     = r_rsp_flags;
  assign io_bus.busy          = r_busy;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: an ALU stub answers after a set latency,
// expected responses are queued at accept and compared at response handshake.
module tb_alu_arbiter;
  localparam int unsigned TMO = 15;

  typedef struct packed {
    logic        id;
    logic [31:0] out;
    logic [4:0]  flags;
  } rsp_t;

  logic soc_clk = 1'b0;
  logic reset   = 1'b0;

  alu_arbiter_if bus_if();

  alu_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .soc_clk (soc_clk),
    .reset   (reset),
    .io_bus  (bus_if)
  );

  always #5 soc_clk = ~soc_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference ALU: returns {err, zero, con_met, overflow, out}
  function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic ov, cm, er;
    r = '0; ov = 1'b0; cm = 1'b0; er = 1'b0;
    case (op)
      5'd0: cm = (a == b);
      5'd1: cm = (a != b);
      5'd6: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd7: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd8: r = a & b;
      5'd9: r = a | b;
      default: er = 1'b1;
    endcase
    return {er, (op > 5'd5) && (r == '0), cm, ov, r};
  endfunction

  int stub_lat  = 2;
  bit stub_hang = 1'b0;
  int stub_cnt  = 0;

  // ALU stub: raises alu_ready stub_lat cycles after alu_dat_ready, unless hung
  always @(negedge soc_clk) begin
    logic [35:0] r;
    if (bus_if.alu_dat_ready && !bus_if.alu_ready) begin
      if (!stub_hang && stub_cnt >= stub_lat) begin
        r = alu_fn(bus_if.alu_instr, bus_if.alu_dat1, bus_if.alu_dat2);
        bus_if.alu_out      = r[31:0];
        bus_if.alu_overflow = r[32];
        bus_if.alu_con_met  = r[33];
        bus_if.alu_zero     = r[34];
        bus_if.alu_err      = r[35];
        bus_if.alu_ready    = 1'b1;
      end else begin
        stub_cnt++;
      end
    end else begin
      bus_if.alu_ready = 1'b0;
      stub_cnt = 0;
    end
  end

  rsp_t        sb_q[$];
  int          acc_order[$];
  int          n_acc = 0, n_acc0 = 0, n_acc1 = 0, n_rsp = 0;
  int          n_dr = 0, n_gap = 0, cyc = 0;
  int          last_acc_edge = 0, last_rsp_edge = 0;
  logic [31:0] last_out = '0;
  logic [4:0]  last_flags = '0;
  logic        last_id = 1'b0;
  bit          bp_phase = 1'b0;
  bit          bp_snap_ok = 1'b0;
  rsp_t        bp_snap;

  always @(posedge soc_clk) cyc++;

  task automatic on_accept(input logic id, input logic [4:0] ins, input logic [31:0] a, input logic [31:0] b);
    rsp_t e;
    logic [35:0] r;
    e.id = id;
    if (ins[4]) begin
      e.out = '0; e.flags = 5'b01000;
    end else if (stub_hang) begin
      e.out = '0; e.flags = 5'b10000;
    end else begin
      r = alu_fn(ins, a, b);
      e.out = r[31:0]; e.flags = {1'b0, r[35:32]};
    end
    sb_q.push_back(e);
    acc_order.push_back(int'(id));
    n_acc++;
    if (id) n_acc1++; else n_acc0++;
    last_acc_edge = cyc + 1;
  endtask

  // Monitor: sampled mid-cycle; handshakes seen here complete on the next rising edge
  always @(negedge soc_clk) begin
    rsp_t e;
    rsp_t cur;
    if (reset) begin
      if (bus_if.alu_dat_ready) n_dr++;
      if (bus_if.busy && !bus_if.alu_dat_ready && !bus_if.rsp_valid) n_gap++;
      if (bus_if.r0_valid && bus_if.r0_ready)
        on_accept(1'b0, bus_if.r0_instr, bus_if.r0_dat1, bus_if.r0_dat2);
      if (bus_if.r1_valid && bus_if.r1_ready)
        on_accept(1'b1, bus_if.r1_instr, bus_if.r1_dat1, bus_if.r1_dat2);
      if (bus_if.rsp_valid) begin
        cur = '{id: bus_if.rsp_id, out: bus_if.rsp_out, flags: bus_if.rsp_flags};
        if (bp_phase && !bus_if.rsp_ready) begin
          if (!bp_snap_ok) begin
            bp_snap = cur;
            bp_snap_ok = 1'b1;
          end else begin
            check_eq("bp_stable", 64'(cur), 64'(bp_snap));
          end
          check_eq("bp_no_grant", 64'({bus_if.r0_ready, bus_if.r1_ready}), 64'(0));
        end
        if (bus_if.rsp_ready) begin
          check_eq("rsp_expected", 64'(sb_q.size() > 0), 64'(1));
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("rsp_id",    64'(cur.id),    64'(e.id));
            check_eq("rsp_out",   64'(cur.out),   64'(e.out));
            check_eq("rsp_flags", 64'(cur.flags), 64'(e.flags));
          end
          last_out = cur.out; last_flags = cur.flags; last_id = cur.id;
          n_rsp++;
          last_rsp_edge = cyc + 1;
        end
      end
    end
  end

  task automatic wait_acc(input int tgt, input int budget);
    int i;
    i = 0;
    while (n_acc < tgt && i < budget) begin
      @(posedge soc_clk); #1;
      i++;
    end
    check_eq("accept_wait", 64'(n_acc >= tgt), 64'(1));
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((bus_if.busy || sb_q.size() != 0) && i < budget) begin
      @(posedge soc_clk); #1;
      i++;
    end
    check_eq("idle_wait", 64'(!bus_if.busy && sb_q.size() == 0), 64'(1));
  endtask

  task automatic issue(input logic id, input logic [4:0] ins, input logic [31:0] a, input logic [31:0] b);
    int tgt;
    tgt = n_acc + 1;
    if (id) begin
      bus_if.r1_instr = ins; bus_if.r1_dat1 = a; bus_if.r1_dat2 = b; bus_if.r1_valid = 1'b1;
    end else begin
      bus_if.r0_instr = ins; bus_if.r0_dat1 = a; bus_if.r0_dat2 = b; bus_if.r0_valid = 1'b1;
    end
    wait_acc(tgt, 100);
    if (id) bus_if.r1_valid = 1'b0;
    else    bus_if.r0_valid = 1'b0;
  endtask

  // Both requesters hold valid until each has had cnt operations accepted
  task automatic run_pair(input int cnt, input logic [31:0] a, input logic [31:0] b);
    int t0, t1, i;
    t0 = n_acc0 + cnt; t1 = n_acc1 + cnt; i = 0;
    bus_if.r0_instr = 5'd6; bus_if.r0_dat1 = a; bus_if.r0_dat2 = b;
    bus_if.r1_instr = 5'd6; bus_if.r1_dat1 = a; bus_if.r1_dat2 = b;
    bus_if.r0_valid = 1'b1; bus_if.r1_valid = 1'b1;
    while ((n_acc0 < t0 || n_acc1 < t1) && i < 400) begin
      @(posedge soc_clk); #1;
      bus_if.r0_valid = (n_acc0 < t0);
      bus_if.r1_valid = (n_acc1 < t1);
      i++;
    end
    bus_if.r0_valid = 1'b0; bus_if.r1_valid = 1'b0;
    check_eq("pair_done", 64'(n_acc0 >= t0 && n_acc1 >= t1), 64'(1));
  endtask

  task automatic check_outs_zero(input string tag);
    check_eq({tag, "_ctl"}, 64'({bus_if.busy, bus_if.rsp_valid, bus_if.rsp_id, bus_if.alu_dat_ready}), 64'(0));
    check_eq({tag, "_alu"}, 64'({bus_if.alu_instr, bus_if.alu_dat1}) | 64'(bus_if.alu_dat2), 64'(0));
    check_eq({tag, "_rsp"}, 64'({bus_if.rsp_out, bus_if.rsp_flags}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp_before;
    bus_if.r0_valid = 1'b0; bus_if.r0_instr = '0; bus_if.r0_dat1 = '0; bus_if.r0_dat2 = '0;
    bus_if.r1_valid = 1'b0; bus_if.r1_instr = '0; bus_if.r1_dat1 = '0; bus_if.r1_dat2 = '0;
    bus_if.alu_ready = 1'b0; bus_if.alu_out = '0; bus_if.alu_overflow = 1'b0;
    bus_if.alu_con_met = 1'b0; bus_if.alu_zero = 1'b0; bus_if.alu_err = 1'b0;
    bus_if.rsp_ready = 1'b1;

    repeat (3) @(posedge soc_clk);
    #1;
    check_outs_zero("reset");
    reset = 1'b1;
    @(posedge soc_clk); #1;

    // Single ADD 5+3 with a two-cycle ALU latency
    stub_lat = 2; n_dr = 0;
    issue(1'b0, 5'd6, 32'd5, 32'd3);
    check_eq("add_dr_rise", 64'(bus_if.alu_dat_ready), 64'(1));
    wait_idle(100);
    check_eq("add_out",   64'(last_out),   64'h8);
    check_eq("add_flags", 64'(last_flags), 64'(0));
    check_eq("add_id",    64'(last_id),    64'(0));
    check_eq("add_dr_len", 64'(n_dr), 64'(3));

    // Out-of-range instruction from r1 is rejected locally
    n_dr = 0;
    issue(1'b1, 5'd16, 32'd7, 32'd9);
    wait_idle(100);
    check_eq("rej_flags", 64'(last_flags), 64'(5'b01000));
    check_eq("rej_out",   64'(last_out),   64'(0));
    check_eq("rej_id",    64'(last_id),    64'(1));
    check_eq("rej_no_dr", 64'(n_dr),       64'(0));

    // Fairness: both requesters contend for four operations each
    stub_lat = 0; acc_order.delete(); n_gap = 0;
    run_pair(4, 32'd1, 32'd1);
    wait_idle(100);
    check_eq("fair_count", 64'(acc_order.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("fair_order%0d", i),
               64'((i < acc_order.size()) ? acc_order[i] : -1), 64'(i % 2));
    end
    check_eq("fair_gaps", 64'(n_gap), 64'(8));

    // Timeout: ALU never answers a SUB
    stub_hang = 1'b1; n_dr = 0;
    issue(1'b0, 5'd7, 32'd10, 32'd3);
    wait_idle(100);
    stub_hang = 1'b0;
    check_eq("tmo_flags", 64'(last_flags), 64'(5'b10000));
    check_eq("tmo_out",   64'(last_out),   64'(0));
    check_eq("tmo_busy_cycles", 64'(n_dr), 64'(TMO));

    // Backpressure: BEQ 5,5 held for five cycles while r1 waits
    stub_lat = 1; bus_if.rsp_ready = 1'b0; bp_phase = 1'b1; bp_snap_ok = 1'b0;
    issue(1'b0, 5'd0, 32'd5, 32'd5);
    bus_if.r1_instr = 5'd6; bus_if.r1_dat1 = 32'd2; bus_if.r1_dat2 = 32'd2; bus_if.r1_valid = 1'b1;
    for (int i = 0; i < 50 && !bus_if.rsp_valid; i++) begin
      @(posedge soc_clk); #1;
    end
    check_eq("bp_rsp_seen", 64'(bus_if.rsp_valid), 64'(1));
    repeat (5) @(posedge soc_clk);
    #1;
    bus_if.rsp_ready = 1'b1;
    wait_acc(n_acc + 1, 50);
    bus_if.r1_valid = 1'b0;
    bp_phase = 1'b0;
    check_eq("bp_flags",   64'(last_flags), 64'(5'b00010));
    check_eq("bp_regrant", 64'(last_acc_edge - last_rsp_edge), 64'(2));
    wait_idle(100);

    // Reset during BUSY discards the operation
    stub_hang = 1'b1;
    issue(1'b0, 5'd8, 32'hF0, 32'h3C);
    repeat (3) @(posedge soc_clk);
    #3;
    check_eq("mid_busy", 64'(bus_if.alu_dat_ready), 64'(1));
    reset = 1'b0;
    #1;
    check_outs_zero("async_rst");
    sb_q.delete();
    stub_hang = 1'b0;
    rsp_before = n_rsp;
    repeat (3) @(posedge soc_clk);
    #1;
    reset = 1'b1;
    acc_order.delete();
    run_pair(1, 32'd4, 32'd4);
    wait_idle(100);
    check_eq("post_rst_first", 64'((acc_order.size() > 0) ? acc_order[0] : -1), 64'(0));
    check_eq("post_rst_rsps",  64'(n_rsp - rsp_before), 64'(2));
    check_eq("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
